// File: rtl/del_meas_pkg.sv
// Shared types and helpers for the multi-channel delay-measurement engine.
package del_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest sample the magnitude helper accepts; narrower samples are sign-extended into it.
  localparam int MAG_W = 32;

  // Reported for a channel that timed out or was aborted; sliced to CNT_W by users.
  localparam logic [63:0] RES_ALL_ONES = '1;

  // One extra bit so the most negative input maps to +2^(MAG_W-1) without overflow.
  function automatic logic [MAG_W:0] mag(input logic signed [MAG_W-1:0] x);
    logic signed [MAG_W:0] xe;
    xe = {x[MAG_W-1], x};
    return xe[MAG_W] ? $unsigned(-xe) : $unsigned(xe);
  endfunction

endpackage

// File: rtl/del_meas_chan.sv
// One timed ADC channel: counts cycles until the sample magnitude crosses the threshold or the timeout hits.
module del_meas_chan
  import del_meas_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       abort,
  input  logic signed [NUM_BITS-1:0] sample,
  input  logic                       valid,
  input  logic        [NUM_BITS-1:0] thresh,
  input  logic        [CNT_W-1:0]    timeout,
  output logic                       latched,
  output logic        [CNT_W-1:0]    result,
  output logic                       timed_out
);

  logic [CNT_W-1:0] cnt_q;
  logic             lat_q;
  logic [MAG_W:0]   mag_w;
  logic             hit;
  logic             expire;
  logic             capture;

  assign mag_w   = mag(MAG_W'(sample));
  assign hit     = valid && (mag_w > (MAG_W + 1)'(thresh));
  assign expire  = (cnt_q == timeout);
  assign capture = enable && !lat_q && (abort || hit || expire);
  // Includes this cycle's capture so the FSM can leave COUNT on the same edge.
  assign latched = lat_q || capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      lat_q     <= 1'b0;
      result    <= '0;
      timed_out <= 1'b0;
    end else if (clear) begin
      cnt_q     <= CNT_W'(1);
      lat_q     <= 1'b0;
      result    <= '0;
      timed_out <= 1'b0;
    end else if (enable && !lat_q) begin
      if (abort || (!hit && expire)) begin
        lat_q     <= 1'b1;
        result    <= RES_ALL_ONES[CNT_W-1:0];
        timed_out <= 1'b1;
      end else if (hit) begin
        lat_q  <= 1'b1;
        result <= cnt_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/del_meas_engine.sv
// Delay-measurement engine: pulses selected DAC lanes, then times each ADC channel to threshold or timeout.
module del_meas_engine
  import del_meas_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int NUM_DAC  = 3,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        meas_start,
  input  logic                        meas_abort,
  input  logic [NUM_DAC-1:0]          dac_mask,
  input  logic [NUM_BITS-1:0]         meas_val,
  input  logic [NUM_BITS-1:0]         meas_thresh,
  input  logic [CNT_W-1:0]            meas_timeout,
  output logic [NUM_DAC*NUM_BITS-1:0] dac_out,
  output logic [NUM_DAC-1:0]          dac_valid,
  input  logic [NUM_CH*NUM_BITS-1:0]  adc_in,
  input  logic [NUM_CH-1:0]           adc_valid,
  output logic [NUM_CH-1:0]           adc_run,
  output logic [NUM_CH*CNT_W-1:0]     result,
  output logic [NUM_CH-1:0]           ch_timeout,
  output logic                        busy,
  output logic                        done
);

  state_t                      state_q, state_d;
  logic [NUM_DAC-1:0]          mask_q;
  logic [NUM_BITS-1:0]         val_q;
  logic [NUM_BITS-1:0]         thresh_q;
  logic [CNT_W-1:0]            timeout_q;
  logic [NUM_CH-1:0]           latched;
  logic [NUM_DAC*NUM_BITS-1:0] lanes;
  logic                        start_ok;

  assign start_ok = (state_q == IDLE) && meas_start && (|dac_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      val_q     <= '0;
      thresh_q  <= '0;
      timeout_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mask_q    <= dac_mask;
        val_q     <= meas_val;
        thresh_q  <= meas_thresh;
        timeout_q <= (meas_timeout == '0) ? '1 : meas_timeout;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = FIRE;
      FIRE:    state_d = COUNT;
      COUNT:   if (&latched) state_d = DONE;
      DONE:    if (!meas_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lanes = '0;
    for (int k = 0; k < NUM_DAC; k++) begin
      lanes[k*NUM_BITS +: NUM_BITS] = mask_q[k] ? val_q : '0;
    end
  end

  always_comb begin
    dac_valid = '0;
    dac_out   = '0;
    adc_run   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      FIRE: begin
        dac_valid = mask_q;
        dac_out   = lanes;
        adc_run   = '1;
        busy      = 1'b1;
      end
      COUNT: begin
        dac_out = lanes;
        adc_run = '1;
        busy    = 1'b1;
      end
      DONE: begin
        dac_out = lanes;
        busy    = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    del_meas_chan #(
      .NUM_BITS(NUM_BITS),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clear    (state_q == FIRE),
      .enable   (state_q == COUNT),
      .abort    (meas_abort),
      .sample   (adc_in[i*NUM_BITS +: NUM_BITS]),
      .valid    (adc_valid[i]),
      .thresh   (thresh_q),
      .timeout  (timeout_q),
      .latched  (latched[i]),
      .result   (result[i*CNT_W +: CNT_W]),
      .timed_out(ch_timeout[i])
    );
  end

endmodule

// File: tb/tb_del_meas_engine.sv
// Vector table plus scoreboard bench for del_meas_engine (default parameters).
module tb_del_meas_engine;

  localparam int NB = 16;
  localparam int ND = 3;
  localparam int NC = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              meas_start = 1'b0;
  logic              meas_abort = 1'b0;
  logic [ND-1:0]     dac_mask = '0;
  logic [NB-1:0]     meas_val = '0;
  logic [NB-1:0]     meas_thresh = '0;
  logic [CW-1:0]     meas_timeout = '0;
  logic [ND*NB-1:0]  dac_out;
  logic [ND-1:0]     dac_valid;
  logic [NC*NB-1:0]  adc_in = '0;
  logic [NC-1:0]     adc_valid = '0;
  logic [NC-1:0]     adc_run;
  logic [NC*CW-1:0]  result;
  logic [NC-1:0]     ch_timeout;
  logic              busy;
  logic              done;

  del_meas_engine #(.NUM_BITS(NB), .NUM_DAC(ND), .NUM_CH(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .meas_start(meas_start), .meas_abort(meas_abort),
    .dac_mask(dac_mask), .meas_val(meas_val), .meas_thresh(meas_thresh),
    .meas_timeout(meas_timeout), .dac_out(dac_out), .dac_valid(dac_valid),
    .adc_in(adc_in), .adc_valid(adc_valid), .adc_run(adc_run), .result(result),
    .ch_timeout(ch_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  mask;
    logic [15:0] val;
    logic [15:0] thresh;
    logic [15:0] timeout;
    logic [15:0] pre;        // sample shown before a channel's crossing cycle
    int          cross0;     // COUNT cycle from which MAC shows samp0 (0 = never)
    logic [15:0] samp0;
    int          cross1;
    logic [15:0] samp1;
    int          abort_cyc;  // 0 = no abort
    int          inval_lo;   // adc_valid low on cycles inval_lo..inval_hi
    int          inval_hi;
    logic [31:0] exp_result; // {NL, MAC}
    logic [1:0]  exp_to;
    int          exp_len;    // cycles spent in COUNT
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  to;
    int          len;
  } exp_t;

  vec_t vt[8];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [ND*NB-1:0] lanes_of(input logic [2:0] m, input logic [15:0] v);
    logic [ND*NB-1:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) if (m[k]) r[k*NB +: NB] = v;
    return r;
  endfunction

  task automatic drive_cycle(input vec_t v, input int n);
    logic [15:0] s0, s1;
    logic        vl;
    s0 = (v.cross0 != 0 && n >= v.cross0) ? v.samp0 : v.pre;
    s1 = (v.cross1 != 0 && n >= v.cross1) ? v.samp1 : v.pre;
    vl = !(n >= v.inval_lo && n <= v.inval_hi);
    adc_in     = {s1, s0};
    adc_valid  = {vl, vl};
    meas_abort = (n == v.abort_cyc);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    int   cyc;
    logic [31:0] res_hold;
    dac_mask     = v.mask;
    meas_val     = v.val;
    meas_thresh  = v.thresh;
    meas_timeout = v.timeout;
    adc_in       = '0;
    adc_valid    = '0;
    meas_abort   = 1'b0;
    meas_start   = 1'b1;
    e.res = v.exp_result; e.to = v.exp_to; e.len = v.exp_len;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({v.name, " fire_dac_valid"}, 64'(dac_valid), 64'(v.mask));
    chk({v.name, " fire_dac_out"}, 64'(dac_out), 64'(lanes_of(v.mask, v.val)));
    chk({v.name, " fire_adc_run"}, 64'(adc_run), 64'(2'b11));
    chk({v.name, " fire_busy"}, 64'(busy), 64'(1));
    // Later changes to the config inputs must not affect this measurement.
    meas_val = 16'h0000; dac_mask = 3'b111; meas_thresh = 16'h0000; meas_timeout = 16'd1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      if (!done) begin
        cyc++;
        if (cyc == 1) begin
          chk({v.name, " count_dac_valid"}, 64'(dac_valid), 64'(0));
          chk({v.name, " count_dac_out"}, 64'(dac_out), 64'(lanes_of(v.mask, v.val)));
        end
        drive_cycle(v, cyc);
      end
    end while (!done && cyc < 200);
    meas_abort = 1'b0;
    if (!done) chk({v.name, " done_wait"}, 64'(done), 64'(1));
    if (sb.size() == 0) begin
      chk({v.name, " scoreboard_empty"}, 64'(0), 64'(1));
    end else begin
      got = sb.pop_front();
      chk({v.name, " count_len"}, 64'(cyc), 64'(got.len));
      chk({v.name, " result"}, 64'(result), 64'(got.res));
      chk({v.name, " ch_timeout"}, 64'(ch_timeout), 64'(got.to));
    end
    chk({v.name, " done_adc_run"}, 64'(adc_run), 64'(0));
    res_hold = result;
    meas_abort = 1'b1;
    @(posedge clk); #1;
    meas_abort = 1'b0;
    chk({v.name, " done_abort_hold"}, 64'({result, ch_timeout}), 64'({res_hold, v.exp_to}));
    @(posedge clk); #1;
    chk({v.name, " no_restart"}, 64'({done, busy}), 64'(2'b11));
    meas_start = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " back_idle"}, 64'({done, busy}), 64'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"cross_5_9", 3'b001, 16'h4000, 16'd100, 16'd0, 16'd100,
              5, 16'd200, 9, 16'hFF00, 0, 0, 0, 32'h0009_0005, 2'b00, 9};
    vt[1] = '{"timeout_20", 3'b001, 16'h1234, 16'd100, 16'd20, 16'd0,
              3, 16'd1000, 0, 16'd0, 0, 0, 0, 32'hFFFF_0003, 2'b10, 20};
    vt[2] = '{"neg_first", 3'b100, 16'h0100, 16'd100, 16'd0, 16'd0,
              1, 16'hFF9B, 1, 16'h8000, 0, 0, 0, 32'h0001_0001, 2'b00, 1};
    vt[3] = '{"neg_strict", 3'b011, 16'h0100, 16'd100, 16'd0, 16'hFF9C,
              4, 16'hFF9B, 4, 16'h8000, 0, 0, 0, 32'h0004_0004, 2'b00, 4};
    vt[4] = '{"strict_to", 3'b001, 16'h0100, 16'd100, 16'd6, 16'hFF9C,
              0, 16'd0, 0, 16'd0, 0, 0, 0, 32'hFFFF_FFFF, 2'b11, 6};
    vt[5] = '{"abort_7", 3'b010, 16'h0200, 16'd100, 16'd0, 16'd0,
              4, 16'd500, 0, 16'd0, 7, 0, 0, 32'hFFFF_0004, 2'b10, 7};
    vt[6] = '{"invalid_2_4", 3'b001, 16'h0200, 16'd100, 16'd0, 16'd0,
              3, 16'd500, 6, 16'd500, 0, 2, 4, 32'h0006_0005, 2'b00, 6};
    vt[7] = '{"mask_110", 3'b110, 16'h8001, 16'd100, 16'd1, 16'd0,
              0, 16'd0, 0, 16'd0, 0, 0, 0, 32'hFFFF_FFFF, 2'b11, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({dac_out, dac_valid, adc_run, result, ch_timeout, busy, done}), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'({busy, done}), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Zero mask must be ignored.
    dac_mask = 3'b000; meas_val = 16'h7FFF; meas_start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("zero_mask_idle", 64'({busy, dac_valid}), 64'(0));
    end
    meas_start = 1'b0;

    // Reset in the middle of COUNT after MAC has already latched.
    dac_mask = 3'b001; meas_val = 16'h4000; meas_thresh = 16'd100; meas_timeout = 16'd0;
    adc_in = {16'd0, 16'd300}; adc_valid = 2'b11; meas_start = 1'b1;
    @(posedge clk); #1;
    meas_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_state", 64'({busy, result}), 64'({1'b1, 16'd0, 16'd1}));
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({dac_out, dac_valid, adc_run, result, ch_timeout, busy, done}), 64'(0));
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 64'({busy, done, result}), 64'(0));
    if (sb.size() != 0) chk("scoreboard_left", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/del_meas_engine.md
Name: del_meas_engine

Overview:
- Parametrised multi-channel delay-measurement engine for the Ising machine datapath. It succeeds the fixed two-channel MAC/NL delay measurement.
- Fires a test pulse on any subset of DAC lanes, then times each ADC channel independently until its magnitude crosses a threshold or a runtime timeout expires.
- Sits between the CPU register bank (trigger, threshold, results) and the DAC/ADC drivers.

Parameters:
- NUM_BITS, 16, sample width (two's complement) for DAC and ADC lanes
- NUM_DAC, 3, number of DAC lanes that can be pulsed (alpha, beta, gamma)
- NUM_CH, 2, number of ADC channels timed (MAC, NL)
- CNT_W, 16, counter/result width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- meas_start  in  1  level trigger; a rising level in IDLE starts a measurement
- meas_abort  in  1  forces early completion
- dac_mask  in  NUM_DAC  lanes to pulse, sampled at start
- meas_val  in  NUM_BITS  pulse amplitude, sampled at start
- meas_thresh  in  NUM_BITS  unsigned magnitude threshold, sampled at start
- meas_timeout  in  CNT_W  timeout in cycles, sampled at start; 0 means all-ones
- dac_out  out  NUM_DAC*NUM_BITS  pulse data, lane k at bits [k*NUM_BITS +: NUM_BITS]
- dac_valid  out  NUM_DAC  one-cycle strobe per lane
- adc_in  in  NUM_CH*NUM_BITS  ADC samples, packed like dac_out
- adc_valid  in  NUM_CH  sample qualifier per channel
- adc_run  out  NUM_CH  enables ADC drivers during measurement
- result  out  NUM_CH*CNT_W  per-channel delay; all-ones means timeout or abort
- ch_timeout  out  NUM_CH  per-channel timeout/abort flag
- busy  out  1  high outside IDLE
- done  out  1  high in DONE state

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, captured config 0.
- State IDLE:
  - If meas_start is high and dac_mask is nonzero, capture mask, meas_val, meas_thresh and meas_timeout, then go to FIRE.
  - A zero mask is ignored and the engine stays in IDLE.
- State FIRE (exactly 1 cycle):
  - dac_valid = captured mask.
  - dac_out = meas_val on masked lanes, 0 on the others.
  - adc_run = all ones.
  - Per-channel counters set to 1; latch flags, result and ch_timeout cleared.
  - Next state is COUNT.
- State COUNT:
  - dac_valid = 0; dac_out holds its value; adc_run stays high.
  - For each channel not yet latched, in priority order:
    1. If adc_valid[i] and mag(adc_in[i]) > thresh (strict), then result[i] = counter[i] and the channel latches.
    2. Else if counter[i] == timeout, then result[i] = all-ones, ch_timeout[i] = 1, and the channel latches.
    3. Else counter[i] increments.
  - When adc_valid[i] is low, that channel's counter still increments, so it counts cycles rather than samples.
  - Once every channel is latched (including several latching in the same cycle), go to DONE on the next edge.
  - If meas_abort is high in COUNT, all unlatched channels get all-ones and ch_timeout = 1 in that cycle, then go to DONE. Already-latched results are kept.
- Latency definition: a crossing present on the first COUNT cycle reports 1. Each further cycle adds 1.
- Magnitude: mag(x) = -x when x is negative, otherwise x.
  - The most negative value maps to 2^(NUM_BITS-1), treated as unsigned with NUM_BITS+1 internal width. No overflow.
- Counter never wraps: the effective timeout is at most all-ones.
- State DONE:
  - done = 1, adc_run = 0.
  - result and ch_timeout are held stable.
  - Return to IDLE when meas_start is low (done clears).
  - meas_abort has no effect in DONE.
- busy = 1 in FIRE, COUNT and DONE.
- Inputs changing mid-measurement have no effect (config is captured at start).
- Reset asserted in any state immediately restores reset values. No partial result survives.

Decomposition:
- Package del_meas_pkg holds:
  - the state enum (IDLE, FIRE, COUNT, DONE), 2 bits
  - the magnitude function
  - the all-ones result constant
- Sub-module del_meas_chan (one per ADC channel, generated NUM_CH times) holds:
  - counter, latch flag, result and timeout flag
  - inputs: clear, enable, abort, sample, valid, thresh, timeout
  - outputs: latched, result, timed_out
- The top level keeps the FSM, config capture and DAC strobe.

Test Plan:
- Crossing at different times: mask=3'b001, val=16'h4000, thresh=100; MAC crosses on COUNT cycle 5, NL on cycle 9 -> result = {9,5}, ch_timeout = 0, done high until meas_start falls.
- Timeout: timeout=20, NL never crosses, MAC crosses at cycle 3 -> MAC result = 3; NL = 16'hFFFF with ch_timeout[1] = 1; COUNT state lasts 20 cycles.
- Negative samples: NL sample = 16'h8000, MAC sample = -101, thresh=100 -> both latch on the first valid cycle. A sample of -100 does not latch, because the comparison is strict.
- Abort and invalid data: abort in COUNT cycle 7 with MAC latched at 4 -> result = {16'hFFFF, 4}, ch_timeout = 2'b10. With adc_valid low for 3 cycles, the counter still advances.
- Mask and reset edge cases:
  - dac_mask=0 with meas_start -> stays in IDLE, busy stays 0.
  - mask=3'b110 -> one-cycle dac_valid = 3'b110.
  - rst pulsed mid-COUNT -> all outputs 0 immediately.
  - meas_start held high after DONE -> no restart until it drops.
